// File: rtl/collect_detect_if.sv
// VGA stream bundle: raster position, sync/blanking strobes and 12-bit rgb.
// The driving stage uses modport out, the consuming stage uses modport in.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/collect_detect.sv
// Player overlay plus collectible hit detection and score keeping on a VGA stream.
// Optional macro COLLECT_COOLDOWN_EN adds a post-hit cooldown of COOLDOWN_FRAMES frames.
module collect_detect #(
   parameter int unsigned PLAYER_SIZE     = 16,
   parameter logic [11:0] KEY_COLOR       = 12'hFF0,
   parameter logic [11:0] PLAYER_COLOR    = 12'h0F0,
   parameter int unsigned SCORE_MAX       = 99,
   parameter int unsigned COOLDOWN_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           vga_in,
   vga_if.out          vga_out,
   input  logic [10:0] player_x,
   input  logic [10:0] player_y,
   output logic        hit,
   output logic [7:0]  score
);

   if (SCORE_MAX > 255) begin : g_bad_score_max
      $error("SCORE_MAX must fit in the 8-bit score");
   end
   if (COOLDOWN_FRAMES < 1) begin : g_bad_cooldown
      $error("COOLDOWN_FRAMES must be at least 1");
   end

   localparam logic [11:0] SIZE12    = 12'(PLAYER_SIZE);
   localparam logic [7:0]  SCORE_TOP = 8'(SCORE_MAX);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      EVAL     = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } timing_t;

   timing_t     tim_d, tim_q;
   logic [11:0] rgb_d, rgb_q;
   logic [10:0] px_d, px_q;
   logic [10:0] py_d, py_q;
   logic        vblnk_d, vblnk_q;
   logic        ovl_d, ovl_q;
   logic        hit_d, hit_q;
   logic [7:0]  score_d, score_q;
   state_t      state_d, state_q;

`ifdef COLLECT_COOLDOWN_EN
   localparam int unsigned     CNT_W    = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
   logic [CNT_W-1:0] cnt_d, cnt_q;
`endif

   logic        blank;
   logic        vblnk_rise;
   logic        in_box;
   logic [11:0] h12, v12, px12, py12;
   logic [7:0]  score_inc;

   // Position compares run one bit wider than the raster so px+PLAYER_SIZE cannot wrap.
   always_comb begin
      h12        = {1'b0, vga_in.hcount};
      v12        = {1'b0, vga_in.vcount};
      px12       = {1'b0, px_q};
      py12       = {1'b0, py_q};
      in_box     = (h12 >= px12) && (h12 < px12 + SIZE12) &&
                   (v12 >= py12) && (v12 < py12 + SIZE12);
      blank      = vga_in.hblnk | vga_in.vblnk;
      vblnk_rise = vga_in.vblnk & ~vblnk_q;
      score_inc  = (score_q == SCORE_TOP) ? 8'd0 : score_q + 8'd1;
   end

   // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
   always_comb begin
      tim_d   = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                  hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                  hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk};
      rgb_d   = blank  ? 12'h000 :
                in_box ? PLAYER_COLOR : vga_in.rgb;
      vblnk_d = vga_in.vblnk;
      px_d    = px_q;
      py_d    = py_q;
      if (vga_in.hcount == 11'd0 && vga_in.vcount == 11'd0) begin
         px_d = player_x;
         py_d = player_y;
      end

      // Key test uses the incoming rgb, i.e. before the player overlay replaces it.
      ovl_d   = ovl_q | (~blank & in_box & (vga_in.rgb == KEY_COLOR));
      state_d = state_q;
      hit_d   = 1'b0;
      score_d = score_q;
`ifdef COLLECT_COOLDOWN_EN
      cnt_d   = cnt_q;
`endif

      // hit and score are decided on the way into EVAL so they are visible during EVAL.
      case (state_q)
         SCAN: begin
            if (vblnk_rise) begin
               state_d = EVAL;
               if (ovl_q) begin
                  hit_d   = 1'b1;
                  score_d = score_inc;
               end
            end
         end
         EVAL: begin
            ovl_d   = 1'b0;
            state_d = SCAN;
`ifdef COLLECT_COOLDOWN_EN
            if (hit_q) begin
               state_d = COOLDOWN;
               cnt_d   = '0;
            end
`endif
         end
`ifdef COLLECT_COOLDOWN_EN
         COOLDOWN: begin
            if (vblnk_rise) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  ovl_d   = 1'b0;
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`endif
         default: state_d = SCAN;
      endcase
   end

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tim_q   <= '0;
         rgb_q   <= '0;
         px_q    <= '0;
         py_q    <= '0;
         vblnk_q <= 1'b0;
         ovl_q   <= 1'b0;
         hit_q   <= 1'b0;
         score_q <= '0;
         state_q <= SCAN;
`ifdef COLLECT_COOLDOWN_EN
         cnt_q   <= '0;
`endif
      end else begin
         tim_q   <= tim_d;
         rgb_q   <= rgb_d;
         px_q    <= px_d;
         py_q    <= py_d;
         vblnk_q <= vblnk_d;
         ovl_q   <= ovl_d;
         hit_q   <= hit_d;
         score_q <= score_d;
         state_q <= state_d;
`ifdef COLLECT_COOLDOWN_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign vga_out.hcount = tim_q.hcount;
   assign vga_out.vcount = tim_q.vcount;
   assign vga_out.hsync  = tim_q.hsync;
   assign vga_out.vsync  = tim_q.vsync;
   assign vga_out.hblnk  = tim_q.hblnk;
   assign vga_out.vblnk  = tim_q.vblnk;
   assign vga_out.rgb    = rgb_q;
   assign hit            = hit_q;
   assign score          = score_q;

endmodule

// File: tb/tb_collect_detect.sv
// Directed bench for collect_detect using compact synthetic frames: only the
// pixels around the areas of interest are streamed, one pixel per clock.
module tb_collect_detect;

`ifdef COLLECT_COOLDOWN_EN
   localparam bit CD = 1'b1;
`else
   localparam bit CD = 1'b0;
`endif
   localparam logic [11:0] KEY = 12'hFF0;
   localparam logic [11:0] BG  = 12'h00F;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] player_x;
   logic [10:0] player_y;
   logic        hit;
   logic [7:0]  score;

   vga_if vin ();
   vga_if vout ();

   collect_detect dut (
      .clk      (clk),
      .rst      (rst),
      .vga_in   (vin),
      .vga_out  (vout),
      .player_x (player_x),
      .player_y (player_y),
      .hit      (hit),
      .score    (score)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int hit_cnt = 0;
   int px_m    = 0;
   int py_m    = 0;

   bit          exp_valid = 1'b0;
   logic [11:0] exp_rgb;
   int          exp_h, exp_v;
   logic        exp_hs, exp_vs, exp_hb, exp_vb;

   function automatic bit inbox(input int h, input int v);
      return (h >= px_m) && (h < px_m + 16) && (v >= py_m) && (v < py_m + 16);
   endfunction

   // Samples the output of the previous pixel, then drives the next one.
   task automatic pixel(input int h, input int v, input logic hb, input logic vb,
                        input logic [11:0] c);
      @(negedge clk);
      if (hit === 1'b1) hit_cnt++;
      if (exp_valid) begin
         checks++;
         if (vout.rgb !== exp_rgb || vout.hcount !== 11'(exp_h) || vout.vcount !== 11'(exp_v) ||
             vout.hsync !== exp_hs || vout.vsync !== exp_vs ||
             vout.hblnk !== exp_hb || vout.vblnk !== exp_vb) begin
            errors++;
            $display("FAIL pixel(%0d,%0d) got rgb=%h h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b want rgb=%h hs=%b vs=%b hb=%b vb=%b",
                     exp_h, exp_v, vout.rgb, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                     vout.hblnk, vout.vblnk, exp_rgb, exp_hs, exp_vs, exp_hb, exp_vb);
         end
      end
      vin.hcount = 11'(h);
      vin.vcount = 11'(v);
      vin.hsync  = (h % 2) == 1;
      vin.vsync  = vb;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.rgb    = c;
      exp_rgb    = (hb || vb) ? 12'h000 : (inbox(h, v) ? 12'h0F0 : c);
      exp_h      = h;
      exp_v      = v;
      exp_hs     = (h % 2) == 1;
      exp_vs     = vb;
      exp_hb     = hb;
      exp_vb     = vb;
      exp_valid  = 1'b1;
      if (h == 0 && v == 0) begin
         px_m = int'(player_x);
         py_m = int'(player_y);
      end
   endtask

   task automatic frame_body(input int x0, input int y0, input int n,
                             input int kx, input int ky, input int ks);
      hit_cnt = 0;
      pixel(0, 0, 1'b0, 1'b0, 12'h000);
      for (int v = y0; v < y0 + n; v++)
         for (int h = x0; h < x0 + n; h++)
            pixel(h, v, 1'b0, 1'b0,
                  (h >= kx && h < kx + ks && v >= ky && v < ky + ks) ? KEY : BG);
   endtask

   // Vertical blank; the rising-edge pixel is an in-box key pixel and must not count.
   task automatic frame_blank();
      repeat (4) pixel(105, 105, 1'b0, 1'b1, KEY);
   endtask

   task automatic check_frame(input string name, input int exp_hits, input int exp_score);
      checks++;
      if (hit_cnt !== exp_hits) begin
         errors++;
         $display("FAIL %s hits got %0d want %0d", name, hit_cnt, exp_hits);
      end
      checks++;
      if (score !== 8'(exp_score)) begin
         errors++;
         $display("FAIL %s score got %0d want %0d", name, score, exp_score);
      end
      hit_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      exp_valid  = 1'b0;
      vin.hcount = 11'd1;
      vin.vcount = 11'd1;
      vin.hsync  = 1'b0;
      vin.vsync  = 1'b0;
      vin.hblnk  = 1'b1;
      vin.vblnk  = 1'b0;
      vin.rgb    = 12'h000;
      px_m       = 0;
      py_m       = 0;
      hit_cnt    = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      player_x   = 11'd0;
      player_y   = 11'd0;
      vin.hcount = 11'd5;
      vin.vcount = 11'd7;
      vin.hsync  = 1'b1;
      vin.vsync  = 1'b1;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      vin.rgb    = 12'hABC;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", vout.rgb); end
      checks++; if (vout.hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount got %0d want 0", vout.hcount); end
      checks++; if (vout.vcount !== 11'd0) begin errors++; $display("FAIL reset_vcount got %0d want 0", vout.vcount); end
      checks++; if (vout.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b want 0", vout.hsync); end
      checks++; if (vout.vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %b want 0", vout.vsync); end
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", hit); end
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      // px/py come out of reset at 0, so pixel (5,7) lies inside the player box.
      checks++; if (vout.rgb !== 12'h0F0) begin errors++; $display("FAIL post_reset_rgb got %h want 0f0", vout.rgb); end
      checks++; if (vout.hcount !== 11'd5) begin errors++; $display("FAIL post_reset_hcount got %0d want 5", vout.hcount); end
      checks++; if (vout.vcount !== 11'd7) begin errors++; $display("FAIL post_reset_vcount got %0d want 7", vout.vcount); end
      checks++; if (vout.hsync !== 1'b1) begin errors++; $display("FAIL post_reset_hsync got %b want 1", vout.hsync); end
   endtask

   task automatic test_collect();
      do_reset();
      player_x = 11'd100;
      player_y = 11'd100;
      frame_body(98, 98, 20, 105, 105, 10); frame_blank();
      check_frame("collect_f1", 1, 1);
      frame_body(98, 98, 20, 105, 105, 10); frame_blank();
      check_frame("collect_f2", CD ? 0 : 1, CD ? 1 : 2);
      frame_body(98, 98, 20, 105, 105, 10); frame_blank();
      check_frame("collect_f3", CD ? 0 : 1, CD ? 1 : 3);
   endtask

   task automatic test_blank_key();
      do_reset();
      player_x = 11'd100;
      player_y = 11'd100;
      hit_cnt  = 0;
      pixel(0, 0, 1'b0, 1'b0, 12'h000);
      for (int v = 104; v < 112; v++)
         for (int h = 104; h < 112; h++)
            pixel(h, v, 1'b1, 1'b0, KEY);
      frame_blank();
      check_frame("blank_key", 0, 0);
   endtask

   task automatic test_overlay();
      do_reset();
      player_x = 11'd0;
      player_y = 11'd0;
      frame_body(0, 0, 20, 200, 200, 10);
      for (int h = 196; h < 206; h++) pixel(h, 200, 1'b0, 1'b0, KEY);
      pixel(15, 15, 1'b0, 1'b0, 12'h123);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== 12'h0F0) begin errors++; $display("FAIL ovl_corner got %h want 0f0", vout.rgb); end
      pixel(16, 15, 1'b0, 1'b0, 12'h123);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== 12'h123) begin errors++; $display("FAIL ovl_right_edge got %h want 123", vout.rgb); end
      pixel(15, 16, 1'b0, 1'b0, 12'h456);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== 12'h456) begin errors++; $display("FAIL ovl_bottom_edge got %h want 456", vout.rgb); end
      pixel(5, 5, 1'b1, 1'b0, 12'hFFF);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL ovl_hblank got %h want 000", vout.rgb); end
      frame_blank();
      check_frame("overlay_far_key", 0, 0);
   endtask

   task automatic test_move();
      do_reset();
      player_x = 11'd100;
      player_y = 11'd100;
      hit_cnt  = 0;
      pixel(0, 0, 1'b0, 1'b0, 12'h000);
      for (int v = 98; v < 106; v++)
         for (int h = 98; h < 118; h++)
            pixel(h, v, 1'b0, 1'b0, (h >= 105 && h < 115 && v >= 105) ? KEY : BG);
      player_x = 11'd300;
      pixel(110, 110, 1'b0, 1'b0, BG);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== 12'h0F0) begin errors++; $display("FAIL move_hold got %h want 0f0", vout.rgb); end
      pixel(305, 105, 1'b0, 1'b0, BG);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== BG) begin errors++; $display("FAIL move_not_yet got %h want 00f", vout.rgb); end
      frame_blank();
      check_frame("move_f1", 1, 1);
      frame_body(98, 98, 20, 105, 105, 10);
      pixel(110, 110, 1'b0, 1'b0, BG);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== BG) begin errors++; $display("FAIL move_old_pos got %h want 00f", vout.rgb); end
      pixel(305, 105, 1'b0, 1'b0, BG);
      @(posedge clk); #1;
      checks++; if (vout.rgb !== 12'h0F0) begin errors++; $display("FAIL move_new_pos got %h want 0f0", vout.rgb); end
      frame_blank();
      check_frame("move_f2", 0, 1);
   endtask

`ifndef COLLECT_COOLDOWN_EN
   task automatic test_wrap();
      do_reset();
      player_x = 11'd100;
      player_y = 11'd100;
      for (int f = 1; f <= 99; f++) begin
         frame_body(98, 98, 20, 105, 105, 10); frame_blank();
         check_frame("wrap_preload", 1, f);
      end
      frame_body(98, 98, 20, 105, 105, 10); frame_blank();
      check_frame("wrap_to_zero", 1, 0);
   endtask
`else
   task automatic test_cooldown();
      int exp_score;
      do_reset();
      player_x  = 11'd100;
      player_y  = 11'd100;
      exp_score = 0;
      for (int f = 1; f <= 64; f++) begin
         frame_body(98, 98, 20, 105, 105, 10); frame_blank();
         if (f == 1 || f == 32 || f == 63) exp_score++;
         check_frame("cooldown", (f == 1 || f == 32 || f == 63) ? 1 : 0, exp_score);
      end
   endtask
`endif

   task automatic test_rst_mid();
      do_reset();
      player_x = 11'd100;
      player_y = 11'd100;
      frame_body(98, 98, 20, 105, 105, 10); frame_blank();
      check_frame("rst_mid_f1", 1, 1);
      frame_body(98, 98, 20, 105, 105, 10);
      pixel(0, 300, 1'b0, 1'b0, BG);
      @(negedge clk);
      rst       = 1'b1;
      exp_valid = 1'b0;
      px_m      = 0;
      py_m      = 0;
      #1;
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_mid_score got %0d want 0", score); end
      checks++; if (vout.vcount !== 11'd0) begin errors++; $display("FAIL rst_mid_vcount got %0d want 0", vout.vcount); end
      checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL rst_mid_rgb got %h want 000", vout.rgb); end
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_mid_hit got %b want 0", hit); end
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      hit_cnt = 0;
      frame_blank();
      check_frame("rst_mid_discard", 0, 0);
      frame_body(98, 98, 20, 105, 105, 10); frame_blank();
      check_frame("rst_mid_new_overlap", 1, 1);
   endtask

   initial begin
      test_reset();
      test_collect();
      test_blank_key();
      test_overlay();
      test_move();
`ifndef COLLECT_COOLDOWN_EN
      test_wrap();
`else
      test_cooldown();
`endif
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d checks", checks);
      $fatal(1, "simulation time limit reached");
   end

endmodule
